// File: rtl/stream_mux_n.sv
// stream_mux_n: N-to-1 valid/ready stream multiplexer with a registered output
// stage. Channel selection is either external (MODE=0, via sel) or
// round-robin among requesting channels (MODE=1). Every output word carries
// the index of the channel it came from.
//
// Ports:
//   clk        sole clock, rising edge
//   reset      synchronous, active-high reset
//   in_data    CHANNELS*WIDTH input words, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (combinational, one-hot or zero)
//   sel        channel select, MODE=0 only
//   out_data   registered output word
//   out_chan   registered source channel of out_data
//   out_valid  registered output valid
//   out_ready  consumer ready
module stream_mux_n #(
    parameter  int unsigned WIDTH    = 8,
    parameter  int unsigned CHANNELS = 4,
    parameter  int unsigned MODE     = 0,
    localparam int unsigned CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    input  logic [CH_W-1:0]           sel,
    output logic [WIDTH-1:0]          out_data,
    output logic [CH_W-1:0]           out_chan,
    output logic                      out_valid,
    input  logic                      out_ready
);

    // One extra bit so ptr + offset never overflows before the wrap.
    localparam int unsigned IDX_W = CH_W + 1;

    logic               r_out_valid;
    logic [WIDTH-1:0]   r_out_data;
    logic [CH_W-1:0]    r_out_chan;
    logic [CH_W-1:0]    r_ptr;

    logic               w_load_en;
    logic               w_grant_valid;
    logic [CH_W-1:0]    w_grant;
    logic [IDX_W-1:0]   w_idx;
    logic [CHANNELS-1:0] w_ready;
    logic               w_xfer;
    logic [WIDTH-1:0]   w_data;

    // Output register can take a word when empty or draining this cycle.
    assign w_load_en = !r_out_valid || out_ready;

    // Grant selection: external select, or first valid channel from ptr.
    always_comb begin
        w_grant       = '0;
        w_grant_valid = 1'b0;
        w_idx         = '0;
        if (MODE == 0) begin
            if (IDX_W'(sel) < IDX_W'(CHANNELS)) begin
                w_grant       = sel;
                w_grant_valid = 1'b1;
            end
        end else begin
            for (int unsigned k = 0; k < CHANNELS; k++) begin
                // Modulo by subtraction keeps the wrap exact for any CHANNELS.
                w_idx = IDX_W'(r_ptr) + IDX_W'(k);
                if (w_idx >= IDX_W'(CHANNELS)) begin
                    w_idx = w_idx - IDX_W'(CHANNELS);
                end
                if (!w_grant_valid && in_valid[CH_W'(w_idx)]) begin
                    w_grant       = CH_W'(w_idx);
                    w_grant_valid = 1'b1;
                end
            end
        end
    end

    // Ready is one-hot on the granted channel, suppressed during reset.
    always_comb begin
        w_ready = '0;
        if (!reset && w_load_en && w_grant_valid) begin
            w_ready[w_grant] = 1'b1;
        end
    end

    assign w_xfer   = |(in_valid & w_ready);
    assign w_data   = in_data[w_grant*WIDTH +: WIDTH];
    assign in_ready = w_ready;

    // Output register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_ptr       <= '0;
        end else begin
            if (w_xfer) begin
                r_out_data  <= w_data;
                r_out_chan  <= w_grant;
                r_out_valid <= 1'b1;
                r_ptr       <= (w_grant == CH_W'(CHANNELS - 1)) ? '0 : w_grant + CH_W'(1);
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_stream_mux_n.sv
// tb_stream_mux_n: table-driven checks of stream_mux_n in four configurations
// (4ch fixed, 4ch round-robin, 3ch round-robin, 3ch fixed) with a scoreboard
// of words expected in the output register.
module tb_stream_mux_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // inst 0: CHANNELS=4, MODE=0
    logic [31:0] d0_in_data;
    logic [3:0]  d0_in_valid, d0_in_ready;
    logic [1:0]  d0_sel, d0_out_chan;
    logic [7:0]  d0_out_data;
    logic        d0_out_valid, d0_out_ready;
    // inst 1: CHANNELS=4, MODE=1
    logic [31:0] d1_in_data;
    logic [3:0]  d1_in_valid, d1_in_ready;
    logic [1:0]  d1_sel, d1_out_chan;
    logic [7:0]  d1_out_data;
    logic        d1_out_valid, d1_out_ready;
    // inst 2: CHANNELS=3, MODE=1
    logic [23:0] d2_in_data;
    logic [2:0]  d2_in_valid, d2_in_ready;
    logic [1:0]  d2_sel, d2_out_chan;
    logic [7:0]  d2_out_data;
    logic        d2_out_valid, d2_out_ready;
    // inst 3: CHANNELS=3, MODE=0
    logic [23:0] d3_in_data;
    logic [2:0]  d3_in_valid, d3_in_ready;
    logic [1:0]  d3_sel, d3_out_chan;
    logic [7:0]  d3_out_data;
    logic        d3_out_valid, d3_out_ready;

    stream_mux_n #(.WIDTH(8), .CHANNELS(4), .MODE(0)) u_d0 (
        .clk(clk), .reset(reset), .in_data(d0_in_data), .in_valid(d0_in_valid),
        .in_ready(d0_in_ready), .sel(d0_sel), .out_data(d0_out_data),
        .out_chan(d0_out_chan), .out_valid(d0_out_valid), .out_ready(d0_out_ready));
    stream_mux_n #(.WIDTH(8), .CHANNELS(4), .MODE(1)) u_d1 (
        .clk(clk), .reset(reset), .in_data(d1_in_data), .in_valid(d1_in_valid),
        .in_ready(d1_in_ready), .sel(d1_sel), .out_data(d1_out_data),
        .out_chan(d1_out_chan), .out_valid(d1_out_valid), .out_ready(d1_out_ready));
    stream_mux_n #(.WIDTH(8), .CHANNELS(3), .MODE(1)) u_d2 (
        .clk(clk), .reset(reset), .in_data(d2_in_data), .in_valid(d2_in_valid),
        .in_ready(d2_in_ready), .sel(d2_sel), .out_data(d2_out_data),
        .out_chan(d2_out_chan), .out_valid(d2_out_valid), .out_ready(d2_out_ready));
    stream_mux_n #(.WIDTH(8), .CHANNELS(3), .MODE(0)) u_d3 (
        .clk(clk), .reset(reset), .in_data(d3_in_data), .in_valid(d3_in_valid),
        .in_ready(d3_in_ready), .sel(d3_sel), .out_data(d3_out_data),
        .out_chan(d3_out_chan), .out_valid(d3_out_valid), .out_ready(d3_out_ready));

    typedef struct {
        logic       rst;
        int         inst;
        logic [3:0] valid;
        logic [1:0] sel;
        logic       ordy;
        logic [3:0] exp_ready;
        logic       exp_xfer;
        logic [1:0] exp_chan;
    } vec_t;

    typedef struct {
        logic [1:0] chan;
        logic [7:0] data;
    } exp_t;

    vec_t       vecs[$];
    exp_t       sb[$];
    logic [7:0] chan_data [4] = '{8'h77, 8'h11, 8'hA5, 8'h3C};
    int         checks   = 0;
    int         failures = 0;

    task automatic add(input logic rst, input int inst, input logic [3:0] valid,
                       input logic [1:0] sel, input logic ordy, input logic [3:0] er,
                       input logic ex, input logic [1:0] ec);
        vec_t t;
        t.rst = rst; t.inst = inst; t.valid = valid; t.sel = sel; t.ordy = ordy;
        t.exp_ready = er; t.exp_xfer = ex; t.exp_chan = ec;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d actual=%0h required=%0h", name, row, act, exp);
        end
    endtask

    // Drive the target instance; the others idle with no valid input.
    task automatic drive(input int inst, input logic [3:0] valid, input logic [1:0] sel,
                         input logic ordy);
        d0_in_valid = '0; d0_sel = '0; d0_out_ready = 1'b1;
        d1_in_valid = '0; d1_sel = '0; d1_out_ready = 1'b1;
        d2_in_valid = '0; d2_sel = '0; d2_out_ready = 1'b1;
        d3_in_valid = '0; d3_sel = '0; d3_out_ready = 1'b1;
        case (inst)
            0: begin d0_in_valid = valid;      d0_sel = sel; d0_out_ready = ordy; end
            1: begin d1_in_valid = valid;      d1_sel = sel; d1_out_ready = ordy; end
            2: begin d2_in_valid = valid[2:0]; d2_sel = sel; d2_out_ready = ordy; end
            default: begin d3_in_valid = valid[2:0]; d3_sel = sel; d3_out_ready = ordy; end
        endcase
    endtask

    function automatic logic [3:0] get_ready(input int inst);
        case (inst)
            0:       return d0_in_ready;
            1:       return d1_in_ready;
            2:       return {1'b0, d2_in_ready};
            default: return {1'b0, d3_in_ready};
        endcase
    endfunction

    task automatic get_out(input int inst, output logic ov, output logic [1:0] oc,
                           output logic [7:0] od);
        case (inst)
            0:       begin ov = d0_out_valid; oc = d0_out_chan; od = d0_out_data; end
            1:       begin ov = d1_out_valid; oc = d1_out_chan; od = d1_out_data; end
            2:       begin ov = d2_out_valid; oc = d2_out_chan; od = d2_out_data; end
            default: begin ov = d3_out_valid; oc = d3_out_chan; od = d3_out_data; end
        endcase
    endtask

    initial begin
        vec_t       t;
        logic       ov;
        logic [1:0] oc;
        logic [7:0] od;

        d0_in_data = {8'h3C, 8'hA5, 8'h11, 8'h77};
        d1_in_data = {8'h3C, 8'hA5, 8'h11, 8'h77};
        d2_in_data = {8'hA5, 8'h11, 8'h77};
        d3_in_data = {8'hA5, 8'h11, 8'h77};
        reset = 1'b1;
        drive(0, 4'b0000, 2'd0, 1'b1);

        //  rst inst valid    sel   ordy  exp_ready xfer chan
        // 4ch fixed select
        add(1, 0, 4'b1111, 2'd2, 1, 4'b0000, 0, 2'd0);
        add(0, 0, 4'b1111, 2'd2, 1, 4'b0100, 1, 2'd2);
        add(0, 0, 4'b1111, 2'd3, 1, 4'b1000, 1, 2'd3);
        add(0, 0, 4'b1111, 2'd1, 0, 4'b0000, 0, 2'd0);
        add(0, 0, 4'b1111, 2'd1, 1, 4'b0010, 1, 2'd1);
        add(0, 0, 4'b0000, 2'd0, 1, 4'b0001, 0, 2'd0);
        add(0, 0, 4'b0000, 2'd0, 0, 4'b0001, 0, 2'd0);
        // 4ch round-robin fairness: 0,1,2,3,0,1
        add(1, 1, 4'b1111, 2'd0, 1, 4'b0000, 0, 2'd0);
        add(0, 1, 4'b1111, 2'd0, 1, 4'b0001, 1, 2'd0);
        add(0, 1, 4'b1111, 2'd0, 1, 4'b0010, 1, 2'd1);
        add(0, 1, 4'b1111, 2'd0, 1, 4'b0100, 1, 2'd2);
        add(0, 1, 4'b1111, 2'd0, 1, 4'b1000, 1, 2'd3);
        add(0, 1, 4'b1111, 2'd0, 1, 4'b0001, 1, 2'd0);
        add(0, 1, 4'b1111, 2'd0, 1, 4'b0010, 1, 2'd1);
        // backpressure for 5 cycles holding ch1/0x11, then ch2 loads
        for (int i = 0; i < 5; i++) add(0, 1, 4'b1111, 2'd0, 0, 4'b0000, 0, 2'd0);
        add(0, 1, 4'b1111, 2'd0, 1, 4'b0100, 1, 2'd2);
        // walk ptr to 2 with a word held, then reset mid-operation
        add(0, 1, 4'b1111, 2'd0, 1, 4'b1000, 1, 2'd3);
        add(0, 1, 4'b1111, 2'd0, 1, 4'b0001, 1, 2'd0);
        add(0, 1, 4'b1111, 2'd0, 1, 4'b0010, 1, 2'd1);
        add(1, 1, 4'b1111, 2'd0, 1, 4'b0000, 0, 2'd0);
        add(0, 1, 4'b1111, 2'd0, 1, 4'b0001, 1, 2'd0);
        // sparse: only ch1 and ch3 valid, alternate 1,3,1,3
        add(0, 1, 4'b1010, 2'd0, 1, 4'b0010, 1, 2'd1);
        add(0, 1, 4'b1010, 2'd0, 1, 4'b1000, 1, 2'd3);
        add(0, 1, 4'b1010, 2'd0, 1, 4'b0010, 1, 2'd1);
        add(0, 1, 4'b1010, 2'd0, 1, 4'b1000, 1, 2'd3);
        add(0, 1, 4'b0000, 2'd0, 1, 4'b0000, 0, 2'd0);
        add(0, 1, 4'b0000, 2'd0, 1, 4'b0000, 0, 2'd0);
        // 3ch round-robin: 0,1,2,0 then wrap from ptr=2 to ch0
        add(1, 2, 4'b0111, 2'd0, 1, 4'b0000, 0, 2'd0);
        add(0, 2, 4'b0111, 2'd0, 1, 4'b0001, 1, 2'd0);
        add(0, 2, 4'b0111, 2'd0, 1, 4'b0010, 1, 2'd1);
        add(0, 2, 4'b0111, 2'd0, 1, 4'b0100, 1, 2'd2);
        add(0, 2, 4'b0111, 2'd0, 1, 4'b0001, 1, 2'd0);
        add(0, 2, 4'b0110, 2'd0, 1, 4'b0010, 1, 2'd1);
        add(0, 2, 4'b0001, 2'd0, 1, 4'b0001, 1, 2'd0);
        add(0, 2, 4'b0000, 2'd0, 1, 4'b0000, 0, 2'd0);
        // 3ch fixed: sel=3 is out of range, no grant, output drains
        add(1, 3, 4'b0111, 2'd1, 1, 4'b0000, 0, 2'd0);
        add(0, 3, 4'b0111, 2'd1, 1, 4'b0010, 1, 2'd1);
        add(0, 3, 4'b0111, 2'd3, 1, 4'b0000, 0, 2'd0);
        add(0, 3, 4'b0111, 2'd3, 1, 4'b0000, 0, 2'd0);

        for (int r = 0; r < vecs.size(); r++) begin
            t     = vecs[r];
            reset = t.rst;
            drive(t.inst, t.valid, t.sel, t.ordy);
            #1;
            chk("in_ready", r, 32'(get_ready(t.inst)), 32'(t.exp_ready));
            // Scoreboard mirrors the output register at the coming edge.
            if (t.ordy && sb.size() > 0) void'(sb.pop_front());
            if (t.exp_xfer) sb.push_back('{t.exp_chan, chan_data[t.exp_chan]});
            if (t.rst) sb.delete();
            @(posedge clk);
            #1;
            get_out(t.inst, ov, oc, od);
            chk("out_valid", r, 32'(ov), 32'(sb.size() > 0));
            if (sb.size() > 0) begin
                chk("out_chan", r, 32'(oc), 32'(sb[0].chan));
                chk("out_data", r, 32'(od), 32'(sb[0].data));
            end else if (t.rst) begin
                chk("rst_out_chan", r, 32'(oc), 32'd0);
                chk("rst_out_data", r, 32'(od), 32'd0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/stream_mux_n.md
# stream_mux_n

Parametrised N-to-1 multiplexer for valid/ready streams with a registered output stage and two selection modes: externally selected channel, or round-robin arbitration among requesting channels. It is the next generation of the team's 4-to-1 mux and is generalised in data width, channel count and mode. It sits between several producers, such as switch/button capture or UART RX, and a single consumer, such as a display driver or TX path, in Basys3 designs. Each output word is tagged with its source channel.

## Interface
- WIDTH, 8: data bits per channel, ≥1.
- CHANNELS, 4: number of input channels, ≥2.
- MODE, 0: 0 = fixed select via `sel`; 1 = round-robin.
- CH_W, derived: `$clog2(CHANNELS)`, minimum 1. This is a localparam, not overridable.

- clk  in  1  sole clock; all logic updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- in_data  in  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  CHANNELS  per-channel valid.
- in_ready  out  CHANNELS  per-channel ready; combinational, at most one bit high.
- sel  in  CH_W  channel select, used only when MODE=0.
- out_data  out  WIDTH  registered output word.
- out_chan  out  CH_W  registered source channel of out_data.
- out_valid  out  1  registered output valid.
- out_ready  in  1  consumer ready.

## Operation
- Output register states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- load_en = !out_valid || out_ready.
- The register may accept a new word in the same cycle the old word drains. This gives full throughput.
- Grant selection:
  - MODE=0: grant=sel. If sel ≥ CHANNELS, there is no grant and all in_ready are 0.
  - MODE=1: scan channels ptr, ptr+1, …, ptr+CHANNELS-1, wrapping modulo CHANNELS. The first channel with in_valid=1 is granted. If no channel is valid, there is no grant.
- in_ready[i] = load_en && grant_valid && grant==i. All other bits are 0.
  - In MODE=0, in_ready[sel] follows load_en even when in_valid[sel]=0.
- Transfer on input i: in_valid[i] && in_ready[i]. On the next edge:
  - out_data ← channel i data
  - out_chan ← i
  - out_valid ← 1
- If the output drains (out_valid && out_ready) with no input transfer, out_valid ← 0. out_data and out_chan hold their last values.
- If the output is FULL and out_ready=0, out_data, out_chan and out_valid must not change.
- Round-robin pointer ptr:
  - On an input transfer on channel g, ptr ← (g+1) mod CHANNELS. The wrap must be correct for CHANNELS that are not a power of two.
  - With no input transfer, ptr is unchanged.
  - ptr is unused when MODE=0.
- Simultaneous drain and accept: the new word replaces the old one; out_valid stays 1.
- Reset, including mid-transfer, has priority over all other activity. Reset values:
  - out_valid=0
  - out_data=0
  - out_chan=0
  - ptr=0
  - Any held word is discarded.
- While reset is asserted, in_ready is forced to all zeros.

## Timing
- Input-to-output latency is 1 cycle. A word accepted at edge k is presented with out_valid=1 after edge k.
- Sustained throughput is 1 word/cycle when out_ready is held at 1.
- in_ready depends combinationally on out_valid, out_ready, in_valid, sel and ptr. There is no combinational path from in_data to any output.
- out_data, out_chan and out_valid are driven directly from flops.
- After reset deasserts, the first accept can occur on the first edge at which reset=0.

## Test plan
- Fixed select, MODE=0:
  - Stimulus: CHANNELS=4, sel=2, in_valid=4'b1111, in_data ch2=0xA5, out_ready=1.
  - Required response: in_ready=4'b0100; one cycle later out_data=0xA5, out_chan=2, out_valid=1.
  - Then set sel=3 (ch3 data 0x3C): out_data=0x3C and out_chan=3 on the next cycle.
- Round-robin fairness, MODE=1:
  - Stimulus: all four channels held valid, out_ready=1.
  - Required response: out_chan sequence 0,1,2,3,0,1 on consecutive cycles, with out_valid continuously 1.
- Sparse round-robin with wrap:
  - Stimulus: MODE=1, only ch1 and ch3 valid, both held.
  - Required response: grants alternate 1,3,1,3. ch0 and ch2 never see in_ready=1.
- Backpressure:
  - Stimulus: output FULL with out_chan=1, data 0x11; out_ready=0 for 5 cycles.
  - Required response: out_data, out_chan and out_valid stay constant; all in_ready=0.
  - Then raise out_ready for 1 cycle: the next granted word (ch2) is loaded in that same cycle.
- Non-power-of-two channel count:
  - Stimulus: CHANNELS=3, MODE=1, all channels valid.
  - Required response: grant sequence 0,1,2,0.
  - Also in MODE=0 with sel=3: all in_ready=0 and out_valid falls to 0 after the drain.
- Reset mid-operation:
  - Stimulus: assert reset for 1 cycle while out_valid=1 and ptr=2.
  - Required response: the next cycle shows out_valid=0, out_data=0, out_chan=0.
  - The first grant after release with all channels valid goes to ch0.
